// File: rtl/grid_cursor_ctrl.sv
// rtl/grid_cursor_ctrl.sv - debounced push-button cursor controller for a COLS x ROWS key grid
module grid_cursor_ctrl #(
  parameter int COLS         = 3,
  parameter int ROWS         = 4,
  parameter int XW           = 4,
  parameter int YW           = 4,
  parameter int INIT_X       = 1,
  parameter int INIT_Y       = 1,
  parameter int DEB_CYCLES   = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int WRAP         = 0,
  parameter int CW           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  output logic [XW-1:0]    cursor_x,
  output logic [YW-1:0]    cursor_y,
  output logic [XW+YW-1:0] cursor_idx,
  output logic             moved,
  output logic             sel_pulse
);

  localparam int NB = 5;
  localparam int IW = XW + YW;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 select.
  logic [NB-1:0] raw, s1, s2, deb, deb_q, press;
  logic [CW-1:0] deb_cnt [NB];
  logic [1:0]    rep_st  [4];
  logic [CW-1:0] rep_cnt [4];
  logic [3:0]    step;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [IW-1:0] idx_n;

  assign raw   = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign press = deb_q & ~deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '1;
      s2    <= '1;
      deb   <= '1;
      deb_q <= '1;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A released level forces IDLE from any state, so a step needs a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
      for (int i = 0; i < 4; i++) begin
        rep_st[i]  <= ST_IDLE;
        rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        step[i] <= 1'b0;
        if (deb[i]) begin
          rep_st[i]  <= ST_IDLE;
          rep_cnt[i] <= '0;
        end else begin
          case (rep_st[i])
            ST_IDLE: begin
              if (press[i]) begin
                step[i]    <= 1'b1;
                rep_cnt[i] <= '0;
                if (REPEAT_DELAY != 0) rep_st[i] <= ST_DELAY;
              end
            end
            ST_DELAY: begin
              if (rep_cnt[i] == DLY_LAST) begin
                step[i]    <= 1'b1;
                rep_st[i]  <= ST_REPEAT;
                rep_cnt[i] <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (rep_cnt[i] == RATE_LAST) begin
                step[i]    <= 1'b1;
                rep_cnt[i] <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + 1'b1;
              end
            end
            default: rep_st[i] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Opposing steps on one axis cancel; the two axes are independent.
  always_comb begin
    nx = cursor_x;
    ny = cursor_y;
    if (step[0] && !step[1]) begin
      if (cursor_y == '0) ny = (WRAP != 0) ? Y_MAX : cursor_y;
      else                ny = cursor_y - YW'(1);
    end else if (step[1] && !step[0]) begin
      if (cursor_y == Y_MAX) ny = (WRAP != 0) ? '0 : cursor_y;
      else                   ny = cursor_y + YW'(1);
    end
    if (step[2] && !step[3]) begin
      if (cursor_x == '0) nx = (WRAP != 0) ? X_MAX : cursor_x;
      else                nx = cursor_x - XW'(1);
    end else if (step[3] && !step[2]) begin
      if (cursor_x == X_MAX) nx = (WRAP != 0) ? '0 : cursor_x;
      else                   nx = cursor_x + XW'(1);
    end
    idx_n = IW'(ny) * IW'(COLS) + IW'(nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_x   <= XW'(INIT_X);
      cursor_y   <= YW'(INIT_Y);
      cursor_idx <= IW'(INIT_Y * COLS + INIT_X);
      moved      <= 1'b0;
      sel_pulse  <= 1'b0;
    end else begin
      cursor_x   <= nx;
      cursor_y   <= ny;
      cursor_idx <= idx_n;
      moved      <= (nx != cursor_x) || (ny != cursor_y);
      sel_pulse  <= press[4];
    end
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// tb/tb_grid_cursor_ctrl.sv - scoreboard bench for grid_cursor_ctrl (clamp, wrap and repeat instances)
module tb_grid_cursor_ctrl;

  typedef struct {
    int x;
    int y;
    int idx;
  } pos_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn [3];
  logic [3:0] cx [3];
  logic [3:0] cy [3];
  logic [7:0] cidx [3];
  logic       mv [3];
  logic       sp [3];

  pos_t qa[$], qw[$], qr[$];
  int   sel_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_sel = 0;

  always #5 clk = ~clk;

  // u0: clamp, no repeat; u1: wrap; u2: 8x8 clamp with auto-repeat
  grid_cursor_ctrl #(.COLS(3), .ROWS(4), .XW(4), .YW(4), .INIT_X(1), .INIT_Y(1),
    .DEB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(1), .WRAP(0), .CW(8)) u_clamp (
    .clk(clk), .rst_n(rst_n), .btn_up(btn[0][0]), .btn_down(btn[0][1]),
    .btn_left(btn[0][2]), .btn_right(btn[0][3]), .btn_sel(btn[0][4]),
    .cursor_x(cx[0]), .cursor_y(cy[0]), .cursor_idx(cidx[0]), .moved(mv[0]), .sel_pulse(sp[0]));

  grid_cursor_ctrl #(.COLS(3), .ROWS(4), .XW(4), .YW(4), .INIT_X(0), .INIT_Y(0),
    .DEB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(1), .WRAP(1), .CW(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .btn_up(btn[1][0]), .btn_down(btn[1][1]),
    .btn_left(btn[1][2]), .btn_right(btn[1][3]), .btn_sel(btn[1][4]),
    .cursor_x(cx[1]), .cursor_y(cy[1]), .cursor_idx(cidx[1]), .moved(mv[1]), .sel_pulse(sp[1]));

  grid_cursor_ctrl #(.COLS(8), .ROWS(8), .XW(4), .YW(4), .INIT_X(0), .INIT_Y(0),
    .DEB_CYCLES(2), .REPEAT_DELAY(10), .REPEAT_RATE(4), .WRAP(0), .CW(8)) u_rep (
    .clk(clk), .rst_n(rst_n), .btn_up(btn[2][0]), .btn_down(btn[2][1]),
    .btn_left(btn[2][2]), .btn_right(btn[2][3]), .btn_sel(btn[2][4]),
    .cursor_x(cx[2]), .cursor_y(cy[2]), .cursor_idx(cidx[2]), .moved(mv[2]), .sel_pulse(sp[2]));

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic expect_pos(input int i, input int x, input int y, input int idx);
    pos_t e;
    e.x = x; e.y = y; e.idx = idx;
    case (i)
      0:       qa.push_back(e);
      1:       qw.push_back(e);
      default: qr.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int i);
    pos_t e;
    int   n;
    n = (i == 0) ? qa.size() : (i == 1) ? qw.size() : qr.size();
    if (n == 0) begin
      check($sformatf("moved_extra_u%0d", i), int'(mv[i]), 0);
      return;
    end
    case (i)
      0:       e = qa.pop_front();
      1:       e = qw.pop_front();
      default: e = qr.pop_front();
    endcase
    check($sformatf("x_u%0d", i), int'(cx[i]), e.x);
    check($sformatf("y_u%0d", i), int'(cy[i]), e.y);
    check($sformatf("idx_u%0d", i), int'(cidx[i]), e.idx);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 3; i++) if (mv[i]) pop_chk(i);
      if (sp[0]) begin
        if (sel_q.size() == 0) check("sel_extra", int'(sp[0]), 0);
        else begin
          void'(sel_q.pop_front());
          n_sel++;
        end
      end
      for (int i = 1; i < 3; i++) if (sp[i]) check($sformatf("sel_idle_u%0d", i), int'(sp[i]), 0);
    end
  end

  task automatic hold(input int i, input logic [4:0] mask, input int n);
    @(negedge clk);
    btn[i] = btn[i] & ~mask;
    repeat (n) @(negedge clk);
    btn[i] = btn[i] | mask;
    repeat (30) @(negedge clk);
  endtask

  task automatic chk_pos(input string tag, input int i, input int x, input int y, input int idx);
    check({tag, "_x"}, int'(cx[i]), x);
    check({tag, "_y"}, int'(cy[i]), y);
    check({tag, "_idx"}, int'(cidx[i]), idx);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) btn[i] = 5'h1f;
    repeat (3) @(negedge clk);
    chk_pos("rst_u0", 0, 1, 1, 4);
    chk_pos("rst_u1", 1, 0, 0, 0);
    chk_pos("rst_u2", 2, 0, 0, 0);
    check("rst_moved", int'(mv[0]), 0);
    check("rst_sel", int'(sp[0]), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clamp instance: step right, then clamp at right edge
    expect_pos(0, 2, 1, 5);
    hold(0, 5'b01000, 20);
    hold(0, 5'b01000, 20);
    chk_pos("clamp_right", 0, 2, 1, 5);
    // 3-cycle glitch rejected, longer press accepted, then clamp at top
    hold(0, 5'b00001, 3);
    chk_pos("glitch", 0, 2, 1, 5);
    expect_pos(0, 2, 0, 2);
    hold(0, 5'b00001, 10);
    hold(0, 5'b00001, 10);
    // up+down cancel, then two diagonal left+down moves
    hold(0, 5'b00011, 10);
    chk_pos("cancel", 0, 2, 0, 2);
    expect_pos(0, 1, 1, 4);
    hold(0, 5'b00110, 10);
    expect_pos(0, 0, 2, 6);
    hold(0, 5'b00110, 10);
    sel_q.push_back(1);
    hold(0, 5'b10000, 50);

    // wrap instance
    expect_pos(1, 2, 0, 2);
    hold(1, 5'b00100, 10);
    expect_pos(1, 2, 3, 11);
    hold(1, 5'b00001, 10);
    expect_pos(1, 2, 0, 2);
    hold(1, 5'b00010, 10);
    expect_pos(1, 0, 0, 0);
    hold(1, 5'b01000, 10);

    // auto-repeat: steps at t=0,10,14,18,22,26 while held
    for (int k = 1; k <= 6; k++) expect_pos(2, 0, k, k * 8);
    hold(2, 5'b00010, 29);
    chk_pos("repeat", 2, 0, 6, 48);

    // reset during a right-hold repeat, button still held across reset release
    for (int k = 1; k <= 3; k++) expect_pos(2, k, 6, 48 + k);
    @(negedge clk);
    btn[2][3] = 1'b0;
    repeat (22) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_pos("midrst_u2", 2, 0, 0, 0);
    chk_pos("midrst_u0", 0, 1, 1, 4);
    check("midrst_moved", int'(mv[2]), 0);
    check("repeat_q_drained", qr.size(), 0);
    repeat (3) @(negedge clk);
    expect_pos(2, 1, 0, 1);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    btn[2][3] = 1'b1;
    repeat (30) @(negedge clk);
    chk_pos("after_rst", 2, 1, 0, 1);

    check("qa_empty", qa.size(), 0);
    check("qw_empty", qw.size(), 0);
    check("qr_empty", qr.size(), 0);
    check("sel_q_empty", sel_q.size(), 0);
    check("sel_count", n_sel, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
